// File: rtl/metadata_pkg.sv
// metadata_pkg: shared types and helpers for the cache tag/state store and flush walker.
package metadata_pkg;
    typedef enum logic [1:0] {IDLE, SCAN, WB_WAIT, DONE} flush_state_e;

    function automatic int way_width(input int assoc);
        return (assoc > 1) ? $clog2(assoc) : 1;
    endfunction

    function automatic logic is_last(input int s, input int w, input int num_sets, input int assoc);
        return (s == num_sets - 1) && (w == assoc - 1);
    endfunction
endpackage

// File: rtl/metadata_flush_walker.sv
// metadata_flush_walker: flush FSM walking every {set,way} way-first, offering dirty lines
// for writeback and strobing an invalidate for each line it leaves behind.
module metadata_flush_walker
    import metadata_pkg::*;
#(
    parameter int NUM_SETS = 4,
    parameter int SET_SIZE = 2,
    parameter int ASSOC    = 2
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           flush_req,
    input  logic                           wb_ready,
    input  logic                           line_valid,
    input  logic                           line_dirty,
    output logic                           flush_busy,
    output logic                           flush_done,
    output logic                           wb_valid,
    output logic [SET_SIZE-1:0]            scan_set,
    output logic [way_width(ASSOC)-1:0]    scan_way,
    output logic                           line_clear
);
    localparam int WW = way_width(ASSOC);
    localparam logic [WW-1:0] LAST_W = WW'(ASSOC - 1);

    flush_state_e state, nxt;
    logic [SET_SIZE-1:0] s_nxt;
    logic [WW-1:0] w_nxt;
    logic adv, last;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            state    <= IDLE;
            scan_set <= '0;
            scan_way <= '0;
        end else begin
            state    <= nxt;
            scan_set <= s_nxt;
            scan_way <= w_nxt;
        end

    always_comb begin
        nxt        = state;
        s_nxt      = scan_set;
        w_nxt      = scan_way;
        wb_valid   = 1'b0;
        flush_done = 1'b0;
        line_clear = 1'b0;
        adv        = 1'b0;
        last       = is_last(int'(scan_set), int'(scan_way), NUM_SETS, ASSOC);
        case (state)
            IDLE: if (flush_req) begin
                nxt   = SCAN;
                s_nxt = '0;
                w_nxt = '0;
            end
            SCAN: if (line_valid && line_dirty) nxt = WB_WAIT;
                  else begin
                      line_clear = 1'b1;
                      adv        = 1'b1;
                  end
            WB_WAIT: begin
                wb_valid = 1'b1;
                if (wb_ready) begin
                    line_clear = 1'b1;
                    adv        = 1'b1;
                end
            end
            DONE: begin
                flush_done = 1'b1;
                nxt        = IDLE;
            end
            default: nxt = IDLE;
        endcase
        // Way-first increment; the set wraps harmlessly after the last line.
        if (adv) begin
            nxt   = last ? DONE : SCAN;
            w_nxt = (scan_way == LAST_W) ? '0 : scan_way + 1'b1;
            s_nxt = (scan_way == LAST_W) ? scan_set + 1'b1 : scan_set;
        end
    end

    assign flush_busy = (state != IDLE);
endmodule

// File: rtl/metadata_flush.sv
// metadata_flush: per-set/way valid, dirty and tag store with hit detection, LRU victim and flush walker.
// Optional METADATA_TAG_PARITY_EN adds one even-parity bit per tag and a sticky parity_error.
module metadata_flush
    import metadata_pkg::*;
#(
    parameter int NUM_SETS  = 4,
    parameter int SET_SIZE  = 2,
    parameter int TAG_SIZE  = 30,
    parameter int ASSOC     = 2,
    parameter int READ_ONLY = 0
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [SET_SIZE-1:0]         set,
    input  logic [TAG_SIZE-1:0]         tag,
    input  logic                        miss_recovery_mode,
    input  logic                        process_lru_counters,
    input  logic                        clear_selected_valid_bit,
    input  logic                        finish_new_line_install,
    input  logic                        clear_selected_dirty_bit,
    input  logic                        set_selected_dirty_bit,
    input  logic                        flush_req,
    output logic                        flush_busy,
    output logic                        flush_done,
    output logic                        wb_valid,
    input  logic                        wb_ready,
    output logic [SET_SIZE-1:0]         wb_set,
    output logic [way_width(ASSOC)-1:0] wb_way,
    output logic [TAG_SIZE-1:0]         wb_tag,
    output logic                        valid_dirty_bit,
    output logic                        valid_block_match,
    output logic [TAG_SIZE-1:0]         selected_tag,
    output logic [way_width(ASSOC)-1:0] selected_way,
    output logic                        parity_error
);
    localparam int WW = way_width(ASSOC);

    logic valid [NUM_SETS][ASSOC];
    logic dirty [NUM_SETS][ASSOC];
    logic [TAG_SIZE-1:0] tag_arr [NUM_SETS][ASSOC];
    logic [ASSOC-1:0] match, perr_way;
    logic [WW-1:0] hit_way, victim;
    logic line_clear, scan_perr, install_eff;

    metadata_flush_walker #(.NUM_SETS(NUM_SETS), .SET_SIZE(SET_SIZE), .ASSOC(ASSOC)) u_walker (
        .clk        (clk),
        .reset_n    (reset_n),
        .flush_req  (flush_req),
        .wb_ready   (wb_ready),
        .line_valid (valid[wb_set][wb_way]),
        .line_dirty (dirty[wb_set][wb_way] && !scan_perr),
        .flush_busy (flush_busy),
        .flush_done (flush_done),
        .wb_valid   (wb_valid),
        .scan_set   (wb_set),
        .scan_way   (wb_way),
        .line_clear (line_clear)
    );

    assign wb_tag = tag_arr[wb_set][wb_way];

`ifdef METADATA_TAG_PARITY_EN
    logic par_arr [NUM_SETS][ASSOC];
    logic perr_q;
    always_ff @(posedge clk)
        if (install_eff) par_arr[set][selected_way] <= ^tag;
    always_comb
        for (int j = 0; j < ASSOC; j++)
            perr_way[j] = valid[set][j] && ((^tag_arr[set][j]) != par_arr[set][j]);
    assign scan_perr = valid[wb_set][wb_way] && ((^tag_arr[wb_set][wb_way]) != par_arr[wb_set][wb_way]);
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) perr_q <= 1'b0;
        else perr_q <= perr_q | (|perr_way) | (flush_busy & scan_perr);
    assign parity_error = perr_q;
`else
    assign perr_way     = '0;
    assign scan_perr    = 1'b0;
    assign parity_error = 1'b0;
`endif

    always_comb
        for (int j = 0; j < ASSOC; j++)
            match[j] = valid[set][j] && (tag_arr[set][j] == tag) && !perr_way[j];

    // At most one way can hit, so OR-ing the indices is the one-hot to binary encode.
    always_comb begin
        hit_way = '0;
        for (int j = 0; j < ASSOC; j++)
            if (match[j]) hit_way = hit_way | WW'(j);
    end

    assign selected_way      = miss_recovery_mode ? victim : hit_way;
    assign selected_tag      = tag_arr[set][selected_way];
    assign valid_block_match = !flush_busy && (|match);
    assign valid_dirty_bit   = !flush_busy && valid[set][selected_way] && dirty[set][selected_way];
    assign install_eff       = !flush_busy && finish_new_line_install && !clear_selected_valid_bit;

    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) begin
            for (int i = 0; i < NUM_SETS; i++)
                for (int j = 0; j < ASSOC; j++) begin
                    valid[i][j] <= 1'b0;
                    dirty[i][j] <= 1'b0;
                end
        end else if (line_clear) begin
            valid[wb_set][wb_way] <= 1'b0;
            dirty[wb_set][wb_way] <= 1'b0;
        end else if (!flush_busy) begin
            if (clear_selected_valid_bit) valid[set][selected_way] <= 1'b0;
            else if (finish_new_line_install) valid[set][selected_way] <= 1'b1;
            if (set_selected_dirty_bit) dirty[set][selected_way] <= (READ_ONLY == 0);
            else if (clear_selected_dirty_bit || install_eff) dirty[set][selected_way] <= 1'b0;
        end

    always_ff @(posedge clk)
        if (install_eff) tag_arr[set][selected_way] <= tag;

    generate
        if (ASSOC > 1) begin : g_lru
            // Age per way: 0 = MRU, ASSOC-1 = LRU victim; reset ages make way 0 the victim.
            logic [WW-1:0] age [NUM_SETS][ASSOC];
            always_ff @(posedge clk or negedge reset_n)
                if (!reset_n) begin
                    for (int i = 0; i < NUM_SETS; i++)
                        for (int j = 0; j < ASSOC; j++)
                            age[i][j] <= WW'(ASSOC - 1 - j);
                end else if (!flush_busy && process_lru_counters) begin
                    for (int j = 0; j < ASSOC; j++)
                        if (WW'(j) == selected_way) age[set][j] <= '0;
                        else if (age[set][j] < age[set][selected_way]) age[set][j] <= age[set][j] + 1'b1;
                end
            always_comb begin
                victim = '0;
                for (int j = 0; j < ASSOC; j++)
                    if (age[set][j] == WW'(ASSOC - 1)) victim = WW'(j);
            end
        end else begin : g_no_lru
            assign victim = '0;
        end
    endgenerate
endmodule
